// File: rtl/w_output_port_ctrl.sv
// rtl/w_output_port_ctrl.sv - West output-port controller: wormhole lock, credit tracking, crossbar drive.
// Optional credit/grant protocol checker enabled by defining W_CREDIT_ERR_CHK_EN.
module w_output_port_ctrl #(
  parameter int CREDIT_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       grant_n_i,
  input  logic       grant_s_i,
  input  logic       grant_e_i,
  input  logic       grant_l_i,
  input  logic       grant_w_i,
  input  logic       n_flit_valid_i,
  input  logic       s_flit_valid_i,
  input  logic       e_flit_valid_i,
  input  logic       l_flit_valid_i,
  input  logic       n_flit_tail_i,
  input  logic       s_flit_tail_i,
  input  logic       e_flit_tail_i,
  input  logic       l_flit_tail_i,
  input  logic       credit_return_i,
  output logic       n_pop_o,
  output logic       s_pop_o,
  output logic       e_pop_o,
  output logic       l_pop_o,
  output logic [2:0] cs_sel_o,
  output logic       cs_en_o,
  output logic       w_link_valid_o,
  output logic       rr_register_change_order_o,
  output logic       rr_downstream_credit_o,
  output logic       credit_err_o
);

  localparam int CNT_W = $clog2(CREDIT_DEPTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CREDIT_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_e;

  state_e           state_q, state_d;
  logic [3:0]       owner_q, owner_d;
  logic [CNT_W-1:0] credit_cnt_q, credit_cnt_d;
  logic [3:0]       grant_vec, valid_vec, tail_vec, owner_vec;
  logic             multi_grant, credit_ok, xfer, owner_tail, overflow;

  // Vectors ordered {n, s, e, l}; owner is one-hot or zero.
  assign grant_vec   = {grant_n_i, grant_s_i, grant_e_i, grant_l_i};
  assign valid_vec   = {n_flit_valid_i, s_flit_valid_i, e_flit_valid_i, l_flit_valid_i};
  assign tail_vec    = {n_flit_tail_i, s_flit_tail_i, e_flit_tail_i, l_flit_tail_i};
  assign multi_grant = (grant_vec & (grant_vec - 4'd1)) != 4'd0;
  assign owner_vec   = (state_q == LOCKED) ? owner_q : (multi_grant ? 4'd0 : grant_vec);
  assign credit_ok   = credit_cnt_q != '0;
  assign xfer        = (|(owner_vec & valid_vec)) && credit_ok;
  assign owner_tail  = |(owner_vec & tail_vec);
  assign overflow    = credit_return_i && !xfer && (credit_cnt_q == CNT_MAX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= 4'd0;
      credit_cnt_q <= CNT_MAX;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      credit_cnt_q <= credit_cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    case (state_q)
      IDLE: begin
        if (xfer && !owner_tail) begin
          state_d = LOCKED;
          owner_d = owner_vec;
        end
      end
      LOCKED: begin
        if (xfer && owner_tail) begin
          state_d = IDLE;
          owner_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A return arriving with the counter already full is dropped (saturate).
  always_comb begin
    credit_cnt_d = credit_cnt_q;
    if (xfer && !credit_return_i) begin
      credit_cnt_d = credit_cnt_q - CNT_ONE;
    end else if (!xfer && credit_return_i && !overflow) begin
      credit_cnt_d = credit_cnt_q + CNT_ONE;
    end
  end

  always_comb begin
    n_pop_o                    = 1'b0;
    s_pop_o                    = 1'b0;
    e_pop_o                    = 1'b0;
    l_pop_o                    = 1'b0;
    cs_sel_o                   = 3'b010;
    cs_en_o                    = 1'b0;
    rr_register_change_order_o = 1'b0;
    if (xfer) begin
      {n_pop_o, s_pop_o, e_pop_o, l_pop_o} = owner_vec;
      cs_en_o                    = 1'b1;
      rr_register_change_order_o = owner_tail;
      case (owner_vec)
        4'b1000: cs_sel_o = 3'b000;
        4'b0100: cs_sel_o = 3'b001;
        4'b0010: cs_sel_o = 3'b011;
        4'b0001: cs_sel_o = 3'b100;
        default: cs_sel_o = 3'b010;
      endcase
    end
  end

  assign w_link_valid_o         = cs_en_o;
  assign rr_downstream_credit_o = (state_q == IDLE) && credit_ok;

`ifdef W_CREDIT_ERR_CHK_EN
  logic credit_err_q;
  logic err_event;

  assign err_event = overflow || multi_grant || grant_w_i ||
                     ((state_q == IDLE) && (grant_vec != 4'd0) && !multi_grant &&
                      ((grant_vec & valid_vec) == 4'd0));

  always_ff @(posedge clk) begin
    if (reset) begin
      credit_err_q <= 1'b0;
    end else if (err_event) begin
      credit_err_q <= 1'b1;
    end
  end

  assign credit_err_o = credit_err_q;
`else
  logic unused_grant_w;
  assign unused_grant_w = grant_w_i;
  assign credit_err_o   = 1'b0;
`endif

endmodule

// File: tb/tb_w_output_port_ctrl.sv
// tb/tb_w_output_port_ctrl.sv - Directed and randomized checks of w_output_port_ctrl against a behavioural model.
module tb_w_output_port_ctrl;

  localparam int DEPTH = 4;
  localparam logic [3:0] GN = 4'b1000, GS = 4'b0100, GE = 4'b0010, GL = 4'b0001;

  logic clk = 1'b0;
  logic reset;
  logic [3:0] g, v, t;
  logic gw, ret;
  logic n_pop, s_pop, e_pop, l_pop, cs_en, wlv, chg, rrc, err;
  logic [2:0] cs_sel;

  int n_checks = 0;
  int n_err = 0;

  int m_owner;
  int m_cnt;
  bit m_err;
  int e_own;
  bit e_x, e_tl;

  always #5 clk = ~clk;

  w_output_port_ctrl #(.CREDIT_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .grant_n_i(g[3]), .grant_s_i(g[2]), .grant_e_i(g[1]), .grant_l_i(g[0]), .grant_w_i(gw),
    .n_flit_valid_i(v[3]), .s_flit_valid_i(v[2]), .e_flit_valid_i(v[1]), .l_flit_valid_i(v[0]),
    .n_flit_tail_i(t[3]), .s_flit_tail_i(t[2]), .e_flit_tail_i(t[1]), .l_flit_tail_i(t[0]),
    .credit_return_i(ret),
    .n_pop_o(n_pop), .s_pop_o(s_pop), .e_pop_o(e_pop), .l_pop_o(l_pop),
    .cs_sel_o(cs_sel), .cs_en_o(cs_en), .w_link_valid_o(wlv),
    .rr_register_change_order_o(chg), .rr_downstream_credit_o(rrc), .credit_err_o(err)
  );

  // Input index 0..3 = n, s, e, l.
  function automatic bit bitof(input logic [3:0] vec, input int i);
    return vec[3-i];
  endfunction

  function automatic int gcount();
    int c = 0;
    for (int i = 0; i < 4; i++) c += int'(bitof(g, i));
    return c;
  endfunction

  function automatic int gidx();
    for (int i = 0; i < 4; i++) if (bitof(g, i)) return i;
    return -1;
  endfunction

  function automatic void model_comb();
    e_own = m_owner;
    if (e_own < 0 && gcount() == 1) e_own = gidx();
    e_x  = (e_own >= 0) && bitof(v, e_own) && (m_cnt > 0);
    e_tl = e_x && bitof(t, e_own);
  endfunction

  function automatic logic [11:0] model_outs();
    logic [3:0] pops;
    logic [2:0] sel;
    model_comb();
    pops = 4'b0;
    sel  = 3'd2;
    if (e_x) begin
      pops[3-e_own] = 1'b1;
      case (e_own)
        0: sel = 3'd0;
        1: sel = 3'd1;
        2: sel = 3'd3;
        default: sel = 3'd4;
      endcase
    end
    return {pops, sel, e_x, e_x, e_tl, (m_owner < 0) && (m_cnt > 0), m_err};
  endfunction

  function automatic logic [11:0] obs_outs();
    return {n_pop, s_pop, e_pop, l_pop, cs_sel, cs_en, wlv, chg, rrc, err};
  endfunction

  function automatic void model_step();
    int nc;
    if (reset) begin
      m_owner = -1;
      m_cnt   = DEPTH;
      m_err   = 1'b0;
      return;
    end
    model_comb();
    nc = m_cnt - int'(e_x) + int'(ret);
    if (nc > DEPTH) nc = DEPTH;
`ifdef W_CREDIT_ERR_CHK_EN
    begin
      bit ovf;
      ovf = ret && !e_x && (m_cnt == DEPTH);
      if (ovf || gcount() > 1 || gw || (m_owner < 0 && gcount() == 1 && !bitof(v, gidx())))
        m_err = 1'b1;
    end
`endif
    if (m_owner < 0 && e_x && !e_tl) m_owner = e_own;
    else if (m_owner >= 0 && e_x && e_tl) m_owner = -1;
    m_cnt = nc;
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  task automatic apply(input logic [13:0] w);
    {g, gw, v, t, ret} = w;
  endtask

  function automatic logic [13:0] st(input logic [3:0] gg, input logic [3:0] vv,
                                     input logic [3:0] tt, input logic rr);
    return {gg, 1'b0, vv, tt, rr};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    apply(14'd0);
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] obs;
    do_reset();
    #2;
    obs = obs_outs();
    n_checks++;
    if (obs !== 12'b0000_010_0_0_0_1_0) begin
      n_err++;
      $display("FAIL reset_outs got=%b exp=%b", obs, 12'b0000_010_0_0_0_1_0);
    end
    n_checks++;
    if (int'(dut.credit_cnt_q) !== DEPTH) begin
      n_err++;
      $display("FAIL reset_cnt got=%0d exp=%0d", dut.credit_cnt_q, DEPTH);
    end
  endtask

  task automatic test_single_flit();
    logic [13:0] q[$];
    logic [11:0] obs, exp;
    do_reset();
    q = '{st(GN, GN, GN, 0), st(0, 0, 0, 0)};
    foreach (q[i]) begin
      apply(q[i]);
      #2;
      exp = model_outs();
      obs = obs_outs();
      n_checks++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL single_flit cyc%0d got=%b exp=%b", i, obs, exp);
      end
      tick();
    end
    n_checks++;
    if (int'(dut.credit_cnt_q) !== 3) begin
      n_err++;
      $display("FAIL single_flit_cnt got=%0d exp=3", dut.credit_cnt_q);
    end
  endtask

  task automatic test_locked_packet();
    logic [13:0] q[$];
    logic [11:0] obs, exp;
    do_reset();
    q = '{st(GE, GE, 0, 0), st(GL, GL, 0, 0), st(GL, GL, 0, 0), st(GL, GE | GL, 0, 0),
          st(0, GE, GE, 0), st(0, 0, 0, 0)};
    foreach (q[i]) begin
      apply(q[i]);
      #2;
      exp = model_outs();
      obs = obs_outs();
      n_checks++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL locked_pkt cyc%0d got=%b exp=%b", i, obs, exp);
      end
      tick();
    end
    n_checks++;
    if (int'(dut.credit_cnt_q) !== 1) begin
      n_err++;
      $display("FAIL locked_pkt_cnt got=%0d exp=1", dut.credit_cnt_q);
    end
  endtask

  task automatic test_credit_stall();
    logic [13:0] q[$];
    logic [11:0] obs, exp;
    do_reset();
    q = '{st(GS, GS, 0, 0), st(GS, GS, 0, 0), st(GS, GS, 0, 0), st(GS, GS, 0, 0),
          st(0, GS, GS, 0), st(0, GS, GS, 1), st(0, GS, GS, 0), st(0, 0, 0, 0)};
    foreach (q[i]) begin
      apply(q[i]);
      #2;
      exp = model_outs();
      obs = obs_outs();
      n_checks++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL credit_stall cyc%0d got=%b exp=%b", i, obs, exp);
      end
      tick();
    end
    n_checks++;
    if (int'(dut.credit_cnt_q) !== 0) begin
      n_err++;
      $display("FAIL credit_stall_cnt got=%0d exp=0", dut.credit_cnt_q);
    end
  endtask

  task automatic test_credit_return();
    logic [13:0] q[$];
    logic [11:0] obs, exp;
    logic err_exp;
`ifdef W_CREDIT_ERR_CHK_EN
    err_exp = 1'b1;
`else
    err_exp = 1'b0;
`endif
    do_reset();
    q = '{st(GL, GL, GL, 0), st(GL, GL, GL, 0), st(GL, GL, GL, 1),
          st(0, 0, 0, 1), st(0, 0, 0, 1), st(0, 0, 0, 1), st(0, 0, 0, 0)};
    foreach (q[i]) begin
      apply(q[i]);
      #2;
      exp = model_outs();
      obs = obs_outs();
      n_checks++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL credit_return cyc%0d got=%b exp=%b", i, obs, exp);
      end
      tick();
    end
    n_checks++;
    if (int'(dut.credit_cnt_q) !== DEPTH) begin
      n_err++;
      $display("FAIL credit_return_cnt got=%0d exp=%0d", dut.credit_cnt_q, DEPTH);
    end
    n_checks++;
    if (err !== err_exp) begin
      n_err++;
      $display("FAIL credit_err got=%b exp=%b", err, err_exp);
    end
  endtask

  task automatic test_reset_mid_packet();
    logic [11:0] obs, exp;
    do_reset();
    apply(st(GN, GN, 0, 0));
    tick();
    apply(st(0, GN, 0, 0));
    tick();
    tick();
    n_checks++;
    if (int'(dut.credit_cnt_q) !== 1 || rrc !== 1'b0) begin
      n_err++;
      $display("FAIL mid_pkt_pre cnt=%0d rrc=%b exp cnt=1 rrc=0", dut.credit_cnt_q, rrc);
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    apply(14'd0);
    #2;
    exp = model_outs();
    obs = obs_outs();
    n_checks++;
    if (obs !== exp || chg !== 1'b0 || rrc !== 1'b1) begin
      n_err++;
      $display("FAIL mid_pkt_reset got=%b exp=%b", obs, exp);
    end
    n_checks++;
    if (int'(dut.credit_cnt_q) !== DEPTH) begin
      n_err++;
      $display("FAIL mid_pkt_cnt got=%0d exp=%0d", dut.credit_cnt_q, DEPTH);
    end
  endtask

  task automatic test_random();
    logic [11:0] obs, exp;
    int r;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 99) == 0);
      r = $urandom_range(0, 9);
      if (r <= 5 || r == 9) g = 4'b1000 >> $urandom_range(0, 3);
      else if (r <= 7) g = 4'd0;
      else g = 4'($urandom);
      gw  = ($urandom_range(0, 19) == 0);
      v   = 4'($urandom);
      t   = 4'($urandom);
      ret = ($urandom_range(0, 2) == 0);
      #2;
      exp = model_outs();
      obs = obs_outs();
      n_checks++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL random cyc%0d got=%b exp=%b", i, obs, exp);
      end
      tick();
      n_checks++;
      if (int'(dut.credit_cnt_q) !== m_cnt) begin
        n_err++;
        $display("FAIL random_cnt cyc%0d got=%0d exp=%0d", i, dut.credit_cnt_q, m_cnt);
      end
    end
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    apply(14'd0);
    m_owner = -1;
    m_cnt   = DEPTH;
    m_err   = 1'b0;
    @(negedge clk);
    test_reset();
    test_single_flit();
    test_locked_packet();
    test_credit_stall();
    test_credit_return();
    test_reset_mid_packet();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
